// File: rtl/register_write_arbiter_if.sv
// Bundle shared between the requesting units, the write arbiter and the
// controlled register.
//
// Requester side : freeze, req, req_data (slice i = [i*WIDTH +: WIDTH]), req_ack
// Register side  : reg_write_enable, reg_next
// Status         : grant_id (current or last winner), busy
//
// Modports:
//   slave  - the arbiter (consumes requests, drives the write port)
//   master - the requesters / register wrapper (or a testbench)
interface register_write_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic                       freeze;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]         req_ack;
    logic                       reg_write_enable;
    logic [WIDTH-1:0]           reg_next;
    logic [IDW-1:0]             grant_id;
    logic                       busy;

    modport slave (
        input  freeze,
        input  req,
        input  req_data,
        output req_ack,
        output reg_write_enable,
        output reg_next,
        output grant_id,
        output busy
    );

    modport master (
        output freeze,
        output req,
        output req_data,
        input  req_ack,
        input  reg_write_enable,
        input  reg_next,
        input  grant_id,
        input  busy
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing one register write port among NUM_REQ
// requesters. Each transaction is IDLE (arbitrate, latch data) -> WRITE
// (write_enable pulse) -> ACK (one-hot ack pulse, advance pointer).
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-low; clears all state immediately
//   bus    - register_write_arbiter_if.slave (requests, write port, status)
//
// Every output is driven straight from a flop, so nothing combinational
// reaches an output from req/req_data/freeze.
module register_write_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    register_write_arbiter_if.slave      bus
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [IDW-1:0]     rr_ptr_q,  rr_ptr_d;
    logic [IDW-1:0]     grant_q,   grant_d;
    logic [WIDTH-1:0]   data_q,    data_d;
    logic               we_q,      we_d;
    logic [WIDTH-1:0]   next_q,    next_d;
    logic [NUM_REQ-1:0] ack_q,     ack_d;
    logic               busy_q,    busy_d;

    // Unpack the flat data bus into per-requester slices.
    logic [WIDTH-1:0]   req_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_slice[gi] = bus.req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin pick: first set bit scanning upward from rr_ptr_q.
    // NUM_REQ is a power of two, so the IDW-bit sum wraps for free.
    logic               found;
    logic [IDW-1:0]     winner;

    always_comb begin
        logic [IDW-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr_q + IDW'(k);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state and registered-output computation. Outputs are computed
    // for the state being entered, so they line up with state_q.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        we_d     = 1'b0;
        next_d   = '0;
        ack_d    = '0;
        busy_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // freeze only gates the start of a new transaction.
                if (!bus.freeze && found) begin
                    state_d = WRITE;
                    grant_d = winner;
                    data_d  = req_slice[winner];
                    we_d    = 1'b1;
                    next_d  = req_slice[winner];
                    busy_d  = 1'b1;
                end
            end
            WRITE: begin
                // Ack is issued regardless of whether req is still held.
                state_d = ACK;
                ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                busy_d  = 1'b1;
            end
            ACK: begin
                // Move past the winner so other pending requesters go first.
                state_d  = IDLE;
                rr_ptr_d = grant_q + IDW'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            next_q   <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            we_q     <= we_d;
            next_q   <= next_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.reg_write_enable = we_q;
    assign bus.reg_next         = next_q;
    assign bus.req_ack          = ack_q;
    assign bus.grant_id         = grant_q;
    assign bus.busy             = busy_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
module tb_register_write_arbiter;
    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    register_write_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    register_write_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural stand-in for the controlled register.
    logic [WIDTH-1:0] reg_model;
    always @(posedge clock or negedge reset) begin
        if (!reset)                    reg_model <= '0;
        else if (bus.reg_write_enable) reg_model <= bus.reg_next;
    end

    // Inputs change right after a falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_data(input int idx, input logic [WIDTH-1:0] val);
        bus.req_data[idx*WIDTH +: WIDTH] = val;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.req      = '0;
        bus.req_data = '0;
        bus.freeze   = 1'b0;
        reset        = 1'b0;
        #2;
        n_checks++;
        if (bus.reg_write_enable !== 1'b0 || bus.reg_next !== '0 || bus.req_ack !== '0 ||
            bus.grant_id !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: we=%b next=%h ack=%b grant=%0d busy=%b, want all zero",
                     bus.reg_write_enable, bus.reg_next, bus.req_ack, bus.grant_id, bus.busy);
        end
        step();
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.reg_write_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b we=%b, want 0 0", bus.busy, bus.reg_write_enable);
        end
        $display("reset: done");
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        set_data(2, 32'hDEADBEEF);
        step();  // WRITE
        n_checks++;
        if (bus.reg_write_enable !== 1'b1 || bus.reg_next !== 32'hDEADBEEF ||
            bus.grant_id !== 2'd2 || bus.busy !== 1'b1 || bus.req_ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_write: we=%b next=%h grant=%0d busy=%b ack=%b, want 1 deadbeef 2 1 0000",
                     bus.reg_write_enable, bus.reg_next, bus.grant_id, bus.busy, bus.req_ack);
        end
        step();  // ACK
        n_checks++;
        if (bus.req_ack !== 4'b0100 || bus.reg_write_enable !== 1'b0 ||
            bus.reg_next !== '0 || reg_model !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b we=%b next=%h reg=%h, want 0100 0 0 deadbeef",
                     bus.req_ack, bus.reg_write_enable, bus.reg_next, reg_model);
        end
        bus.req = '0;
        step();  // IDLE
        n_checks++;
        if (bus.req_ack !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: ack=%b busy=%b, want 0000 0", bus.req_ack, bus.busy);
        end
        $display("single: grant=2 data=deadbeef");
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 32'h100 + i);
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            step();  // WRITE
            n_checks++;
            if (bus.reg_write_enable !== 1'b1 || bus.reg_next !== 32'h100 + exp_id[t] ||
                bus.grant_id !== 2'(exp_id[t])) begin
                n_fail++;
                $display("FAIL rr_write[%0d]: we=%b next=%h grant=%0d, want 1 %h %0d",
                         t, bus.reg_write_enable, bus.reg_next, bus.grant_id,
                         32'h100 + exp_id[t], exp_id[t]);
            end
            step();  // ACK
            n_checks++;
            if (bus.req_ack !== 4'(1 << exp_id[t])) begin
                n_fail++;
                $display("FAIL rr_ack[%0d]: ack=%b, want %b", t, bus.req_ack, 4'(1 << exp_id[t]));
            end
            if (t == 4) bus.req = '0;
            step();  // IDLE
            n_checks++;
            if (bus.reg_write_enable !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_idle[%0d]: we=%b busy=%b, want 0 0", t, bus.reg_write_enable, bus.busy);
            end
            $display("round_robin: txn %0d grant=%0d data=%h", t, exp_id[t], 32'h100 + exp_id[t]);
        end
    endtask

    task automatic test_wrap();
        // Pointer is at 1 here; serve requester 3 first.
        set_data(3, 32'h333);
        set_data(0, 32'h300);
        bus.req = 4'b1000;
        step();  // WRITE
        n_checks++;
        if (bus.grant_id !== 2'd3 || bus.reg_next !== 32'h333) begin
            n_fail++;
            $display("FAIL wrap_first: grant=%0d next=%h, want 3 333", bus.grant_id, bus.reg_next);
        end
        step();  // ACK
        bus.req = 4'b1001;
        step();  // IDLE
        step();  // WRITE
        n_checks++;
        if (bus.grant_id !== 2'd0 || bus.reg_next !== 32'h300 || bus.reg_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_to_0: grant=%0d next=%h we=%b, want 0 300 1",
                     bus.grant_id, bus.reg_next, bus.reg_write_enable);
        end
        step();  // ACK
        n_checks++;
        if (bus.req_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_ack0: ack=%b, want 0001", bus.req_ack);
        end
        bus.req = 4'b1000;
        step();  // IDLE
        step();  // WRITE
        n_checks++;
        if (bus.grant_id !== 2'd3 || bus.reg_next !== 32'h333) begin
            n_fail++;
            $display("FAIL wrap_then_3: grant=%0d next=%h, want 3 333", bus.grant_id, bus.reg_next);
        end
        step();  // ACK
        bus.req = '0;
        step();  // IDLE
        $display("wrap: 3 -> 0 -> 3");
    endtask

    task automatic test_drop_data();
        // Pointer is at 0 here.
        bus.req = 4'b0001;
        set_data(0, 32'h11);
        step();  // WRITE
        n_checks++;
        if (bus.reg_next !== 32'h11) begin
            n_fail++;
            $display("FAIL drop_write: next=%h, want 11", bus.reg_next);
        end
        bus.req = '0;
        set_data(0, 32'h22);
        step();  // ACK
        n_checks++;
        if (bus.req_ack !== 4'b0001 || reg_model !== 32'h11) begin
            n_fail++;
            $display("FAIL drop_ack: ack=%b reg=%h, want 0001 11", bus.req_ack, reg_model);
        end
        step();  // IDLE
        step();
        n_checks++;
        if (bus.reg_write_enable !== 1'b0 || bus.busy !== 1'b0 || reg_model !== 32'h11) begin
            n_fail++;
            $display("FAIL drop_after: we=%b busy=%b reg=%h, want 0 0 11",
                     bus.reg_write_enable, bus.busy, reg_model);
        end
        $display("drop_data: register kept 11");
    endtask

    task automatic test_freeze();
        int bad = 0;
        bus.freeze = 1'b1;
        bus.req    = 4'b0010;
        set_data(1, 32'h55);
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.reg_write_enable !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL freeze_hold: %0d cycles with activity, want 0", bad);
        end
        bus.freeze = 1'b0;
        step();  // WRITE
        n_checks++;
        if (bus.reg_write_enable !== 1'b1 || bus.reg_next !== 32'h55 || bus.grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL freeze_release: we=%b next=%h grant=%0d, want 1 55 1",
                     bus.reg_write_enable, bus.reg_next, bus.grant_id);
        end
        bus.freeze = 1'b1;  // no effect on an in-flight transaction
        step();  // ACK
        n_checks++;
        if (bus.req_ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL freeze_inflight_ack: ack=%b, want 0010", bus.req_ack);
        end
        bus.req    = '0;
        bus.freeze = 1'b0;
        step();  // IDLE
        $display("freeze: held 10 cycles then granted 1");
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        // Pointer is at 2 here.
        bus.req = 4'b0100;
        set_data(2, 32'h77);
        step();  // WRITE
        n_checks++;
        if (bus.reg_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_write: we=%b, want 1", bus.reg_write_enable);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.reg_write_enable !== 1'b0 || bus.busy !== 1'b0 || bus.req_ack !== '0 ||
            bus.reg_next !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: we=%b busy=%b ack=%b next=%h, want 0 0 0000 0",
                     bus.reg_write_enable, bus.busy, bus.req_ack, bus.reg_next);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.req_ack !== '0 || bus.reg_write_enable !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midrst_no_ack: %0d cycles with ack/we, want 0", bad);
        end
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 32'h100 + i);
        bus.req = 4'b1111;
        reset   = 1'b1;
        step();  // WRITE
        n_checks++;
        if (bus.grant_id !== 2'd0 || bus.reg_next !== 32'h100 || bus.reg_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first_grant: grant=%0d next=%h we=%b, want 0 100 1",
                     bus.grant_id, bus.reg_next, bus.reg_write_enable);
        end
        step();  // ACK
        n_checks++;
        if (bus.req_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_ack: ack=%b, want 0001", bus.req_ack);
        end
        bus.req = '0;
        step();
        $display("reset_mid: aborted, then requester 0 first");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drop_data();
        test_freeze();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Round-robin arbiter that shares the single write port of a generic register (write_enable/next pair) among NUM_REQ requesters in the rvsimple core. Each requester presents a write request with data. The arbiter grants one request at a time, drives the register's write port for exactly one cycle, and returns a one-cycle acknowledge once the new value is visible on the register output. It sits between the requesting units (e.g. CSR update, debug, trap logic) and the register instance it controls.

## Interface

- WIDTH, 32, data width; matches the controlled register's WIDTH.
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- clock  in  1  global clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
- freeze  in  1  when 1, no new grant is issued; an in-flight transaction still completes.
- req  in  NUM_REQ  per-requester request; requester holds it until its ack.
- req_data  in  NUM_REQ*WIDTH  packed data; slice i = bits [i*WIDTH +: WIDTH].
- req_ack  out  NUM_REQ  one-hot, one-cycle acknowledge.
- reg_write_enable  out  1  to the register's write_enable.
- reg_next  out  WIDTH  to the register's next.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last winner.
- busy  out  1  1 in WRITE and ACK states.

## Operation

- FSM states: IDLE, WRITE, ACK. Reset state is IDLE.
- IDLE:
  - If freeze=0 and req≠0, pick the winner as the first set req bit scanning upward from rr_ptr, wrapping at NUM_REQ-1 → 0.
  - Latch the winner index into grant_id and its req_data slice into a data holding register; go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - reg_write_enable=1 and reg_next=latched data for exactly this one cycle; go to ACK.
- ACK:
  - req_ack[grant_id]=1; rr_ptr ← (grant_id+1) mod NUM_REQ; go to IDLE.
- Outside WRITE: reg_write_enable=0 and reg_next=0.
- Outside ACK: req_ack=0.
- Data is sampled only in the IDLE→WRITE cycle. Later changes to req or req_data do not affect the in-flight write.
- A request dropped before ack still completes its write and still gets its ack.
- A requester holding req through its ack is re-arbitrated on the next IDLE cycle. rr_ptr has already advanced past it, so any other pending requester wins first.
- freeze is sampled only in IDLE. Asserting it in WRITE or ACK has no effect until the return to IDLE.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, data holding register=0, req_ack=0, reg_write_enable=0, reg_next=0, busy=0.
- Reset asserted mid-transaction aborts it. No write_enable and no ack is produced after reset asserts.
- The first arbitration after reset starts from requester 0.

## Timing

- Cycle 0 (IDLE): req sampled, winner chosen.
- Cycle 1 (WRITE): write_enable high; the register captures next at the end of cycle 1.
- Cycle 2 (ACK): the register output already holds the new value; req_ack pulses.
- Cycle 3: earliest next IDLE arbitration, so the earliest next write_enable is cycle 4.
- Maximum throughput: one write per 3 cycles. Minimum req→write_enable latency: 1 cycle.
- All outputs are registered or decoded from registered state; no combinational path from req to any output.
- Starvation bound: a continuously asserted request is acked within NUM_REQ transactions, i.e. within 3*NUM_REQ cycles of assertion while freeze=0.

## Test plan

- Single request: req=4'b0100, data slice 2=0xDEADBEEF → write_enable at cycle 1 with reg_next=0xDEADBEEF; req_ack=4'b0100 at cycle 2; grant_id=2.
- All four requesting continuously after reset, data i=0x100+i → writes in order 0x100, 0x101, 0x102, 0x103, 0x100 …, one every 3 cycles; acks rotate 0→1→2→3→0.
- Wrap-around: after serving requester 3, with req=4'b1001 → requester 0 wins next, then requester 3.
- Request dropped and data changed in the WRITE cycle (data 0x11 → 0x22) → register receives 0x11; ack still issued.
- freeze=1 with req=4'b0010 pending → no write_enable for 10 cycles, busy=0. freeze → 0 → write_enable 1 cycle later.
- Reset asserted (0) during the WRITE cycle → reg_write_enable, busy and req_ack drop to 0 immediately; no ack follows. After release with req=4'b1111 → requester 0 is granted first.
